// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and default parameters.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_LOCK_CYCLES      = 1024;
    localparam int DEF_HOLD_CYCLES      = 16;
    localparam int DEF_LOSS_COUNT_WIDTH = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock input, status clear and reset/status outputs of the PLL reset sequencer.
interface pll_reset_sequencer_if
    import pll_seq_pkg::*;
#(
    parameter int LOSS_COUNT_WIDTH = DEF_LOSS_COUNT_WIDTH
) ();

    logic                        pll_locked;
    logic                        clear_status;
    logic                        core_reset_n;
    logic                        ready;
    logic                        lock_lost;
    logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count;

    modport master (
        input  pll_locked,
        input  clear_status,
        output core_reset_n,
        output ready,
        output lock_lost,
        output lock_loss_count
    );

    modport slave (
        output pll_locked,
        output clear_status,
        input  core_reset_n,
        input  ready,
        input  lock_lost,
        input  lock_loss_count
    );

endinterface

// File: rtl/pll_reset_sequencer_sync_ff.sv
// Generic single-bit multi-stage synchroniser, async active-low reset to 0.
module sync_ff
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_in,
    output logic q_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the core in reset until PLL lock is stable, then releases it and flags ready.
//
// state     | meaning
// WAIT_LOCK | core in reset, waiting for synchronised lock
// STABILIZE | lock seen, counting LOCK_CYCLES of continuous lock
// RELEASE   | core reset released, counting HOLD_CYCLES flush interval
// RUN       | core running, ready asserted
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int LOCK_CYCLES      = DEF_LOCK_CYCLES,
    parameter int HOLD_CYCLES      = DEF_HOLD_CYCLES,
    parameter int LOSS_COUNT_WIDTH = DEF_LOSS_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    pll_reset_sequencer_if.master  seq_if
);

    localparam int CNT_W = $clog2(max_int(LOCK_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic                        locked_sync;
    seq_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        core_reset_n_q, core_reset_n_d;
    logic                        ready_q, ready_d;
    logic                        lock_lost_q, lock_lost_d;
    logic [LOSS_COUNT_WIDTH-1:0] loss_count_q, loss_count_d;
    logic                        loss_evt;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d_in    (seq_if.pll_locked),
        .q_out   (locked_sync)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            core_reset_n_q <= 1'b0;
            ready_q        <= 1'b0;
            lock_lost_q    <= 1'b0;
            loss_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            core_reset_n_q <= core_reset_n_d;
            ready_q        <= ready_d;
            lock_lost_q    <= lock_lost_d;
            loss_count_q   <= loss_count_d;
        end
    end

    always_comb begin
        loss_evt = ((state_q == RELEASE) || (state_q == RUN)) && !locked_sync;
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_sync) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end
            end
            STABILIZE: begin
                // A drop here is a pre-release glitch and does not count as a loss
                if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (loss_evt) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (loss_evt) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        core_reset_n_d = (state_d == RELEASE) || (state_d == RUN);
        ready_d        = (state_d == RUN);
        lock_lost_d    = lock_lost_q;
        loss_count_d   = loss_count_q;
        // A loss on the same edge as a clear wins, leaving a count of one
        if (loss_evt) begin
            lock_lost_d = 1'b1;
            if (seq_if.clear_status) begin
                loss_count_d = LOSS_COUNT_WIDTH'(1);
            end else if (loss_count_q != '1) begin
                loss_count_d = loss_count_q + LOSS_COUNT_WIDTH'(1);
            end
        end else if (seq_if.clear_status) begin
            lock_lost_d  = 1'b0;
            loss_count_d = '0;
        end
    end

    assign seq_if.core_reset_n    = core_reset_n_q;
    assign seq_if.ready           = ready_q;
    assign seq_if.lock_lost       = lock_lost_q;
    assign seq_if.lock_loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer with short lock/hold intervals.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    logic clock;
    logic reset_n;
    int   edge_cnt = 0;
    int   base     = 0;
    int   errors   = 0;
    int   checks   = 0;

    typedef struct {
        int         edge_no;
        string      tag;
        logic [4:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    pll_reset_sequencer_if #(.LOSS_COUNT_WIDTH(2)) seq_if ();

    pll_reset_sequencer #(
        .SYNC_STAGES      (2),
        .LOCK_CYCLES      (8),
        .HOLD_CYCLES      (4),
        .LOSS_COUNT_WIDTH (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .seq_if  (seq_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [4:0] obs();
        return {seq_if.core_reset_n, seq_if.ready, seq_if.lock_lost, seq_if.lock_loss_count};
    endfunction

    task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed {crn,rdy,lost,cnt}=%b expected=%b", tag, observed, expected);
        end
    endtask

    // expectation k edges after the current base
    task automatic expect_at(input int k, input string tag, input logic crn, input logic rdy,
                             input logic lost, input logic [1:0] cnt);
        sb_entry_t e;
        e.edge_no = base + k;
        e.tag     = tag;
        e.exp     = {crn, rdy, lost, cnt};
        sb_q.push_back(e);
    endtask

    task automatic tick();
        sb_entry_t e;
        @(posedge clock);
        #1;
        edge_cnt++;
        while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
            e = sb_q.pop_front();
            check(e.tag, obs(), e.exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_lock_seq(input string pfx, input logic lost, input logic [1:0] cnt);
        expect_at(10, {pfx, "_crn_hold"}, 1'b0, 1'b0, lost, cnt);
        expect_at(11, {pfx, "_crn_rise"}, 1'b1, 1'b0, lost, cnt);
        expect_at(14, {pfx, "_rdy_hold"}, 1'b1, 1'b0, lost, cnt);
        expect_at(15, {pfx, "_rdy_rise"}, 1'b1, 1'b1, lost, cnt);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #3 reset_n = 1'b0;
        #1 check(tag, obs(), 5'b0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_cnt;
        reset_n             = 1'b0;
        seq_if.pll_locked   = 1'b0;
        seq_if.clear_status = 1'b0;
        run(2);
        check("reset_state", obs(), 5'b0);
        reset_n = 1'b1;
        tick();

        // power-up
        seq_if.pll_locked = 1'b1;
        base = edge_cnt;
        expect_lock_seq("pu", 1'b0, 2'd0);
        run(16);

        // lock loss in RUN, then re-lock
        seq_if.pll_locked = 1'b0;
        base = edge_cnt;
        expect_at(2, "loss_pre", 1'b1, 1'b1, 1'b0, 2'd0);
        expect_at(3, "loss_fall", 1'b0, 1'b0, 1'b1, 2'd1);
        run(3);
        seq_if.pll_locked = 1'b1;
        base = edge_cnt;
        expect_lock_seq("relock", 1'b1, 2'd1);
        run(16);

        // clear, then four losses saturate the 2-bit counter
        seq_if.clear_status = 1'b1;
        base = edge_cnt;
        expect_at(1, "clr_alone", 1'b1, 1'b1, 1'b0, 2'd0);
        tick();
        seq_if.clear_status = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            seq_if.pll_locked = 1'b0;
            base = edge_cnt;
            expect_at(3, "sat_loss", 1'b0, 1'b0, 1'b1, exp_cnt);
            run(3);
            seq_if.pll_locked = 1'b1;
            base = edge_cnt;
            expect_at(11, "sat_relock", 1'b1, 1'b0, 1'b1, exp_cnt);
            expect_at(15, "sat_ready", 1'b1, 1'b1, 1'b1, exp_cnt);
            run(16);
        end
        seq_if.clear_status = 1'b1;
        base = edge_cnt;
        expect_at(1, "clr_sat", 1'b1, 1'b1, 1'b0, 2'd0);
        tick();
        seq_if.clear_status = 1'b0;

        // clear on the same edge as a loss
        seq_if.pll_locked = 1'b0;
        base = edge_cnt;
        expect_at(3, "clr_vs_loss", 1'b0, 1'b0, 1'b1, 2'd1);
        run(2);
        seq_if.clear_status = 1'b1;
        tick();
        seq_if.clear_status = 1'b0;
        seq_if.pll_locked = 1'b1;
        base = edge_cnt;
        expect_lock_seq("post_clr", 1'b1, 2'd1);
        run(16);

        // reset in RUN clears status; then a glitch during STABILIZE
        mid_cycle_reset("rst_run");
        base = edge_cnt;
        expect_at(6, "gl_pre", 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(11, "gl_no_release", 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(19, "gl_crn_hold", 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(20, "gl_crn_rise", 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(23, "gl_rdy_hold", 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(24, "gl_rdy_rise", 1'b1, 1'b1, 1'b0, 2'd0);
        run(6);
        seq_if.pll_locked = 1'b0;
        run(3);
        seq_if.pll_locked = 1'b1;
        run(16);

        // reset in RELEASE, restart matches power-up timing
        mid_cycle_reset("rst_run2");
        base = edge_cnt;
        expect_at(11, "rel_enter", 1'b1, 1'b0, 1'b0, 2'd0);
        run(12);
        mid_cycle_reset("rst_release");
        base = edge_cnt;
        expect_lock_seq("restart", 1'b0, 2'd0);
        run(16);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed pending=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
